// File: rtl/display_scan_driver_pkg.sv
// Shared constants, FSM state type and helpers for the display scan driver.
package display_scan_driver_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned BIN_W     = 14;
  localparam int unsigned BCD_W     = DIGITS * 4;
  localparam int unsigned SHIFT_CNT = 14;

  localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;
  localparam logic [3:0]       BLANK   = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/display_scan_driver.sv
// Binary-to-BCD converter (double dabble) feeding a multiplexed 4-digit scan
// output with leading-zero blanking.
module display_scan_driver
  import display_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [1:0]       en,
  output logic [3:0]       num
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  sr_q, sr_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [3:0]        cnt_q, cnt_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [CntW-1:0]   rcnt_q;
  logic [1:0]        idx_q;
  logic              unused_adj_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Top adjusted bit is shifted out; a value <= 9999 never sets it.
  assign unused_adj_msb = bcd_adj[BCD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          sr_d    = clamp_bin(bin_in);
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (bin_in > MAX_VAL);
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1]};
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_CNT - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        disp_d  = bcd_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-running digit scan, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (rcnt_q == CntMax) begin
      rcnt_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

  logic blank;

  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      2'd2:    blank = (disp_q[15:8] == 8'd0);
      2'd1:    blank = (disp_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    num = blank ? BLANK : disp_q[4*idx_q +: 4];
  end

  assign en       = idx_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench: decimal-arithmetic reference model plus directed scenarios.
module tb_display_scan_driver;

  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        load;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [1:0]  en;
  logic [3:0]  num;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  display_scan_driver #(
    .REFRESH_DIV (RD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .en       (en),
    .num      (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: conversion latency in cycles, decimal value, scan tick count.
  int m_ticks, m_rem, m_pend, m_disp;
  bit m_ovf, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ticks = 0; m_rem = 0; m_pend = 0; m_disp = 0; m_ovf = 0; m_done = 0;
    end else begin
      m_ticks++;
      m_done = 0;
      if (m_rem == 0) begin
        if (load) begin
          m_rem  = 15;
          m_pend = (int'(bin_in) > 9999) ? 9999 : int'(bin_in);
          m_ovf  = (int'(bin_in) > 9999);
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_disp = m_pend;
          m_done = 1;
        end
      end
    end
  end

  function automatic int exp_num(input int val, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    if (k > 0 && val < p) return 15;
    return (val / p) % 10;
  endfunction

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("en", en, (m_ticks / RD) % 4);
      chk("num", num, exp_num(m_disp, (m_ticks / RD) % 4));
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
    end
  end

  logic [3:0] dig [4];

  task automatic read_disp();
    for (int i = 0; i < 4; i++) dig[i] = 4'bx;
    for (int i = 0; i < 4 * RD + 1; i++) begin
      @(negedge clk);
      dig[en] = num;
    end
  endtask

  task automatic check_disp(input string tag, input int d0, input int d1, input int d2,
                            input int d3);
    read_disp();
    chk({tag, "_d0"}, dig[0], d0);
    chk({tag, "_d1"}, dig[1], d1);
    chk({tag, "_d2"}, dig[2], d2);
    chk({tag, "_d3"}, dig[3], d3);
  endtask

  task automatic convert(input string tag, input logic [13:0] v);
    int first_done, ndone, nbusy;
    first_done = 0; ndone = 0; nbusy = 0;
    @(posedge clk); #2;
    bin_in = v;
    load   = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = i;
      end
    end
    chk({tag, "_done_at"}, first_done, 16);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_busy_cyc"}, nbusy, 15);
  endtask

  initial begin
    int first_done, second_done, ndone, waited;
    rst = 1'b1; load = 1'b0; bin_in = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    chk_en = 1;

    // Asynchronous reset mid-scan, then scan restart sequence.
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_en", en, 0);
    chk("rst_num", num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #3 rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if ((k - 1) % 4 == 0) chk("scan_seq", en, ((k - 1) / 4) % 4);
    end

    convert("c1234", 14'd1234);
    check_disp("d1234", 4, 3, 2, 1);
    convert("c7", 14'd7);
    check_disp("d7", 7, 15, 15, 15);
    convert("c0", 14'd0);
    check_disp("d0", 0, 15, 15, 15);
    convert("c1005", 14'd1005);
    check_disp("d1005", 5, 0, 0, 1);
    convert("c12000", 14'd12000);
    chk("ovf_set", overflow, 1);
    check_disp("d12000", 9, 9, 9, 9);
    convert("c42", 14'd42);
    chk("ovf_clr", overflow, 0);
    check_disp("d42", 2, 4, 15, 15);

    // Contention: load held high, bin_in changes while busy.
    first_done = 0; second_done = 0; ndone = 0;
    @(posedge clk); #2;
    bin_in = 14'd5678;
    load   = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) bin_in = 14'd1111;
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = i;
          chk("model_5678", m_disp, 5678);
        end else if (second_done == 0) begin
          second_done = i;
        end
      end
      if (i == 16) chk("cont_idle_gap", busy, 0);
    end
    load = 1'b0;
    chk("cont_first_done", first_done, 16);
    chk("cont_second_done", second_done, 32);
    chk("cont_done_cnt", ndone, 2);
    waited = 0;
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("cont_drain", busy, 0);
    check_disp("d1111", 1, 1, 1, 1);

    // Abort: reset at cycle 7 of a conversion.
    @(posedge clk); #2;
    bin_in = 14'd4321;
    load   = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_en", en, 0);
    chk("abort_num", num, 0);
    @(posedge clk); #2 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_ovf", overflow, 0);
    check_disp("dabort", 0, 15, 15, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
